// File: rtl/ahb_master_pkg.sv
// Shared types and default widths for the AHB-lite request master.
package ahb_master_pkg;

  localparam int unsigned AhbAddrW     = 8;
  localparam int unsigned AhbDataW     = 32;
  localparam int unsigned AhbFifoDepth = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef struct packed {
    logic                write;
    logic [AhbAddrW-1:0] addr;
    logic [AhbDataW-1:0] wdata;
  } ahb_req_t;

endpackage

// File: rtl/ahb_req_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module ahb_req_fifo
  import ahb_master_pkg::*;
#(
  parameter int unsigned DEPTH = AhbFifoDepth,
  parameter type         req_t = ahb_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  req_t din,
  input  logic pop,
  output logic full,
  output logic empty,
  output req_t head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  req_t            mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  // Storage needs no reset: head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/ahb_req_master.sv
// AHB-lite master: buffers requests, issues single NONSEQ transfers through pipelined
// address/data phases and returns one response pulse per request.
module ahb_req_master
  import ahb_master_pkg::*;
#(
  parameter int unsigned ADDR_W     = AhbAddrW,
  parameter int unsigned DATA_W     = AhbDataW,
  parameter int unsigned FIFO_DEPTH = AhbFifoDepth
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [DATA_W-1:0] hrdata
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t              push_req, head, ap_q, dp_q;
  logic              full, empty, push, pop;
  logic              ap_valid_q, dp_valid_q;
  logic              rsp_valid_q, rsp_write_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign req_ready = ~full;
  assign push      = req_valid & ~full;
  assign pop       = hready & ~empty;
  assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};

  ahb_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .req_t (req_t)
  ) u_fifo (
    .clk   (hclk),
    .rst_n (hresetn),
    .push  (push),
    .din   (push_req),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ap_valid_q  <= 1'b0;
      dp_valid_q  <= 1'b0;
      ap_q        <= '0;
      dp_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      // The data phase completes only on an hready edge, so the response is a single pulse.
      rsp_valid_q <= hready & dp_valid_q;
      if (hready) begin
        dp_valid_q <= ap_valid_q;
        dp_q       <= ap_q;
        ap_valid_q <= ~empty;
        if (!empty) ap_q <= head;
        if (dp_valid_q) begin
          rsp_write_q <= dp_q.write;
          rsp_addr_q  <= dp_q.addr;
          rsp_rdata_q <= dp_q.write ? '0 : hrdata;
        end
      end
    end
  end

  always_comb begin
    htrans = IDLE;
    hwrite = 1'b0;
    haddr  = '0;
    hwdata = '0;
    if (ap_valid_q) begin
      htrans = NONSEQ;
      hwrite = ap_q.write;
      haddr  = ap_q.addr;
    end
    if (dp_valid_q && dp_q.write) hwdata = dp_q.wdata;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = ~empty | ap_valid_q | dp_valid_q;

endmodule
